// File: rtl/pipe_issue_pkg.sv
// rtl/pipe_issue_pkg.sv - shared data width and FSM state encodings for the PC issue block
`ifndef PIPE_ISSUE_DEFINES
`define PIPE_ISSUE_DEFINES
`define DATAWIDTH 32
`endif

package pipe_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } issue_state_t;

endpackage

// File: rtl/pipe_issue.sv
// rtl/pipe_issue.sv - PC issue FSM feeding the first pipeline stage with valid/allow handshake
module pipe_issue
    import pipe_issue_pkg::*;
#(
    parameter logic [`DATAWIDTH-1:0] RESET_PC = '0,
    parameter int                    PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [`DATAWIDTH-1:0] redirect_pc,
    input  logic                  out_allow,
    output logic                  validout,
    output logic [`DATAWIDTH-1:0] dataout,
    output logic                  flush,
    output logic [15:0]           issue_count,
    output logic [1:0]            state
);

    localparam logic [`DATAWIDTH-1:0] STEP = `DATAWIDTH'(PC_STEP);

    issue_state_t          state_q, state_d;
    logic [`DATAWIDTH-1:0] pc_q, pc_d;
    logic                  flush_q, flush_d;
    logic [15:0]           count_q;
    logic                  transfer;

    // Offered PC is valid only in the issuing states, decoded straight from the register
    assign validout    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign transfer    = validout && out_allow;
    assign dataout     = pc_q;
    assign flush       = flush_q;
    assign issue_count = count_q;
    assign state       = state_q;

    // Next-state and next-PC selection; redirect outranks everything while issuing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (start) begin
                    state_d = ST_RUN;
                    // A fresh start from IDLE begins at the reset vector unless a
                    // redirect arrives in the same cycle; HALTED resumes where it stopped.
                    if ((state_q == ST_IDLE) && !redirect_valid) begin
                        pc_d = RESET_PC;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_RUN;
                    flush_d = 1'b1;
                end else if (transfer) begin
                    pc_d = pc_q + STEP;
                    if ((state_q == ST_DRAIN) || halt) begin
                        state_d = ST_HALTED;
                    end
                end else if ((state_q == ST_RUN) && halt) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and flush registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    // Completed-transfer counter, counts regardless of redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (transfer) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_issue.sv
// tb/tb_pipe_issue.sv - directed and randomized self-checking bench for pipe_issue
module tb_pipe_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_allow;
    logic        validout;
    logic [31:0] dataout;
    logic        flush;
    logic [15:0] issue_count;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 drain, 3 halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_flush;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    pipe_issue #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_allow      (out_allow),
        .validout       (validout),
        .dataout        (dataout),
        .flush          (flush),
        .issue_count    (issue_count),
        .state          (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_flush = 1'b0;
        m_cnt   = 16'd0;
    endtask

    task automatic model_step();
        bit offering;
        bit accepted;
        offering = (m_mode == 1) || (m_mode == 2);
        accepted = offering && out_allow;
        m_flush  = 1'b0;
        if (accepted) m_cnt = m_cnt + 16'd1;
        if (!offering) begin
            if (redirect_valid) m_pc = redirect_pc;
            if (start) begin
                if (m_mode == 0 && !redirect_valid) m_pc = 32'h0;
                m_mode = 1;
            end
        end else if (redirect_valid) begin
            m_pc    = redirect_pc;
            m_mode  = 1;
            m_flush = 1'b1;
        end else if (accepted) begin
            m_pc   = m_pc + 32'd4;
            m_mode = (m_mode == 2 || halt) ? 3 : 1;
        end else if (halt && m_mode == 1) begin
            m_mode = 2;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, {30'd0, state}, m_mode[31:0]);
        chk({tag, ".validout"}, {31'd0, validout}, {31'd0, (m_mode == 1 || m_mode == 2)});
        chk({tag, ".dataout"}, dataout, m_pc);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
        chk({tag, ".issue_count"}, {16'd0, issue_count}, {16'd0, m_cnt});
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic s, input logic h, input logic rv, input logic [31:0] rp, input logic oa);
        start          = s;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_allow      = oa;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 32'h0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        step("idle_hold");

        // Start and stream 0,4,8
        set_in(1, 0, 0, 32'h0, 1);
        step("start");
        chk("first_pc", dataout, 32'h0);
        set_in(0, 0, 0, 32'h0, 1);
        step("stream4");
        chk("pc4", dataout, 32'd4);
        step("stream8");
        chk("pc8", dataout, 32'd8);

        // Stall at 8 for three cycles
        out_allow = 0;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_pc", dataout, 32'd8);
            chk("stall_valid", {31'd0, validout}, 32'd1);
        end
        out_allow = 1;
        step("unstall");
        chk("pc12", dataout, 32'd12);
        step("pc16_step");

        // Halt while stalled goes to DRAIN, then HALTED on transfer
        set_in(0, 1, 0, 32'h0, 0);
        step("drain");
        chk("drain_state", {30'd0, state}, 32'd2);
        set_in(0, 0, 0, 32'h0, 1);
        step("halted");
        chk("halted_valid", {31'd0, validout}, 32'd0);
        set_in(1, 0, 0, 32'h0, 1);
        step("resume");
        chk("resume_pc", dataout, 32'd20);
        set_in(0, 0, 0, 32'h0, 1);
        step("pc24_step");

        // Redirect beats halt, one-cycle flush
        set_in(0, 1, 1, 32'h100, 1);
        step("redirect");
        chk("redir_pc", dataout, 32'h100);
        chk("redir_flush", {31'd0, flush}, 32'd1);
        set_in(0, 0, 0, 32'h0, 0);
        step("flush_end");
        chk("flush_low", {31'd0, flush}, 32'd0);

        // PC wrap at the top of the address space
        set_in(0, 0, 1, 32'hFFFF_FFFC, 1);
        step("redir_top");
        set_in(0, 0, 0, 32'h0, 1);
        step("wrap");
        chk("wrap_pc", dataout, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC,
                   ($urandom_range(0, 9) < 7));
            step("rand");
        end

        // Force RUN, then asynchronous reset mid-cycle
        set_in(1, 0, 1, 32'h40, 1);
        step("pre_rst");
        set_in(0, 0, 0, 32'h0, 1);
        step("pre_rst_run");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_valid", {31'd0, validout}, 32'd0);
        chk("async_count", {16'd0, issue_count}, 32'd0);
        check_all("async_rst");
        set_in(0, 0, 0, 32'h0, 0);
        rst_n = 1'b1;
        step("post_rst");
        step("post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
